reg_bank: RTL
=============

Name: reg_bank

Overview:
- Sixteen-entry, 16-bit general-purpose register bank.
- Sits directly upstream of the 16:1 operand select multiplexers; all sixteen register values are driven in parallel on r0..r15 for those muxes to pick from.
- Provides one synchronous write port with full-word, low-byte and load-upper-immediate modes.
- Provides a sequenced bulk-clear engine that sweeps the bank one register per cycle.

Parameters:
- ZERO_R0, 0, when 1 r0 always reads RESET_VAL and writes to address 0 are discarded (includes byte modes)
- RESET_VAL, 16'h0000, value loaded into every register on reset and by the clear sweep

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request, sampled on rising clk
- wr_addr  input  4  destination register index
- wr_mode  input  2  00 full word, 01 low byte, 10 load upper immediate, 11 no write
- wr_data  input  16  write data
- clr_req  input  1  start bulk-clear sweep, sampled on rising clk
- busy  output  1  high while the clear sweep runs
- wr_drop  output  1  registered one-cycle pulse: a write request was discarded
- r0..r15  output  16 each  current register contents, driven straight from the flops

Behaviour:
- Reset (async, any time, including mid-sweep):
  - all registers = RESET_VAL
  - busy = 0, wr_drop = 0
  - FSM = IDLE, sweep pointer = 0
- Write timing: a write takes effect on the rising edge where wr_en=1; the new value appears on rN after that edge. No same-cycle bypass.
- Write modes (reg = register selected by wr_addr):
  - 00: reg = wr_data.
  - 01: reg[7:0] = wr_data[7:0]; reg[15:8] unchanged.
  - 10: reg[15:8] = wr_data[7:0]; reg[7:0] = 8'h00.
  - 11: no change. Not counted as a drop.
- ZERO_R0=1: any write to address 0 is ignored; r0 held at RESET_VAL. Not counted as a drop.
- FSM states:
  - IDLE: busy=0; writes accepted.
  - IDLE -> CLEAR on a clock edge with clr_req=1. Pointer = 0. busy goes high after that edge.
  - CLEAR: each edge writes RESET_VAL to reg[pointer], then pointer+1.
  - CLEAR -> IDLE on the edge that clears reg[15]. The sweep takes exactly 16 cycles.
  - busy falls after the final edge; pointer returns to 0.
- During CLEAR:
  - wr_en=1 with wr_mode!=11 is discarded; wr_drop pulses high for one cycle after that edge.
  - clr_req is ignored; no restart, no extension.
- Same edge, in IDLE, with wr_en=1 and clr_req=1: the write is performed on that edge and the sweep starts on the same edge. The written register is later overwritten by the sweep.
- Registers not yet reached by the sweep keep their values; the outputs show partial-clear progress cycle by cycle.
- Pointer arithmetic is 4-bit with no wrap beyond 15; the exit is decided by pointer==15.
- No combinational path from any input to r0..r15, busy or wr_drop.

Test Plan:
- Reset, then full-word writes of 16'h1000+i to each reg i -> r0..r15 read 16'h1000..16'h100F one cycle after each write.
- With r5=16'hABCD:
  - mode 01 write of 16'h0012 -> r5=16'hAB12.
  - then mode 10 write of 16'h0034 -> r5=16'h3400.
  - then mode 11 write -> r5 stays 16'h3400, wr_drop stays 0.
- Load all regs with 16'hFFFF, pulse clr_req:
  - busy high for exactly 16 cycles.
  - r0 clears on the first edge, r15 on the sixteenth.
  - busy falls after the sixteenth edge.
  - sampling mid-sweep shows r0..r7 cleared and r8..r15 still 16'hFFFF after 8 edges.
- Write 16'h5555 to r3 mid-sweep -> r3 unchanged by the write, wr_drop one-cycle pulse; a second clr_req mid-sweep does not extend busy beyond 16 cycles.
- Same-edge wr_en (r15 <- 16'h7777) and clr_req in IDLE -> r15=16'h7777 visible until the sixteenth sweep edge, then 16'h0000.
- Assert reset 5 cycles into the sweep -> immediately all regs = RESET_VAL, busy=0; after release, a full-word write to r9 works normally.
- ZERO_R0=1 build: write 16'hBEEF to r0 -> r0 stays 16'h0000, wr_drop stays 0.

Source files
------------

// File: rtl/reg_bank_if.sv
// Write/clear bus and parallel register outputs of the register bank.
interface reg_bank_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_mode;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic        wr_drop;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;

    modport master (
        output wr_en, wr_addr, wr_mode, wr_data, clr_req,
        input  busy, wr_drop,
        input  r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, wr_data, clr_req,
        output busy, wr_drop,
        output r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15
    );
endinterface

// File: rtl/reg_bank.sv
// Sixteen-entry 16-bit register bank with one write port and a
// one-register-per-cycle bulk-clear sweep.
module reg_bank #(
    parameter bit          ZERO_R0   = 1'b0,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input logic         clk,
    input logic         reset,
    reg_bank_if.slave   bus
);

    typedef enum logic {StIdle, StClear} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        drop_q, drop_d;
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];
    logic [15:0] wr_word;
    logic        wr_live;

    // A write request that would actually modify a register.
    assign wr_live = bus.wr_en && (bus.wr_mode != 2'b11) &&
                     !(ZERO_R0 && (bus.wr_addr == 4'd0));

    // Merge write data with the current register contents according to the mode.
    always_comb begin
        wr_word = regs_q[bus.wr_addr];
        unique case (bus.wr_mode)
            2'b00:   wr_word = bus.wr_data;
            2'b01:   wr_word = {regs_q[bus.wr_addr][15:8], bus.wr_data[7:0]};
            2'b10:   wr_word = {bus.wr_data[7:0], 8'h00};
            default: wr_word = regs_q[bus.wr_addr];
        endcase
    end

    // Next-state: writes in idle, sweep in clear; writes during the sweep are dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;
        regs_d  = regs_q;
        unique case (state_q)
            StIdle: begin
                if (wr_live) begin
                    regs_d[bus.wr_addr] = wr_word;
                end
                // Same-edge write and clear: write lands now, sweep overwrites it later.
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = 4'd0;
                end
            end
            StClear: begin
                regs_d[ptr_q] = RESET_VAL;
                drop_d        = wr_live;
                if (ptr_q == 4'd15) begin
                    state_d = StIdle;
                    ptr_d   = 4'd0;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
        endcase
    end

    // State, pointer, drop pulse and register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 4'd0;
            drop_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.busy    = (state_q == StClear);
    assign bus.wr_drop = drop_q;

    assign bus.r0  = ZERO_R0 ? RESET_VAL : regs_q[0];
    assign bus.r1  = regs_q[1];
    assign bus.r2  = regs_q[2];
    assign bus.r3  = regs_q[3];
    assign bus.r4  = regs_q[4];
    assign bus.r5  = regs_q[5];
    assign bus.r6  = regs_q[6];
    assign bus.r7  = regs_q[7];
    assign bus.r8  = regs_q[8];
    assign bus.r9  = regs_q[9];
    assign bus.r10 = regs_q[10];
    assign bus.r11 = regs_q[11];
    assign bus.r12 = regs_q[12];
    assign bus.r13 = regs_q[13];
    assign bus.r14 = regs_q[14];
    assign bus.r15 = regs_q[15];

endmodule
